mmio_input_port: RTL and testbench

Memory-mapped input/output responder on the core's data-memory bus, answering load/store requests issued by the Memory stage. It synchronizes the board switches, debounces the push buttons, and captures button press events in sticky flags that software polls and clears. It also holds the display register that feeds the seven-segment digit converter. It sits beside data memory: the address decode (`hit_o`) selects which of the two drives read data into the Writeback stage.

---
 rtl/mmio_pkg.sv | 34 +++
 rtl/input_debouncer.sv | 50 +++++
 rtl/mmio_input_port.sv | 126 ++++++++++++
 tb/tb_mmio_input_port.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared register map, default window base and STATUS layout for the MMIO input port.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0400;

    localparam logic [7:0] OFF_SW_STATE = 8'h00;
    localparam logic [7:0] OFF_BTN_EDGE = 8'h04;
    localparam logic [7:0] OFF_DISP     = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;

    localparam int unsigned STATUS_PEND_BIT = 0;
    localparam int unsigned STATUS_CNT_LSB  = 4;
    localparam int unsigned STATUS_CNT_MSB  = 11;

    typedef enum logic [2:0] {
        RegSw,
        RegBtnEdge,
        RegDisp,
        RegStatus,
        RegNone
    } reg_sel_e;

    // Byte-lane bits are ignored, so every access resolves to a whole word.
    function automatic reg_sel_e decode_offset(input logic [7:0] off);
        reg_sel_e sel;
        sel = RegNone;
        if (off[7:2] == OFF_SW_STATE[7:2]) sel = RegSw;
        if (off[7:2] == OFF_BTN_EDGE[7:2]) sel = RegBtnEdge;
        if (off[7:2] == OFF_DISP[7:2])     sel = RegDisp;
        if (off[7:2] == OFF_STATUS[7:2])   sel = RegStatus;
        return sel;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// One button: 2-flop synchronizer, stability counter and a rising-edge pulse that is
// high in the cycle before the accepted state rises, so captures land on the same edge.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_stable;
    logic [CntW-1:0] r_cnt;
    logic            w_stable_d;
    logic [CntW-1:0] w_cnt_d;

    always_comb begin
        w_stable_d = r_stable;
        w_cnt_d    = '0;
        if (r_sync != r_stable) begin
            if (r_cnt == CntMax) begin
                w_stable_d = r_sync;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = w_stable_d & ~r_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta   <= i_btn;
            r_sync   <= r_meta;
            r_stable <= w_stable_d;
            r_cnt    <= w_cnt_d;
        end
    end

endmodule

// File: rtl/mmio_input_port.sv
// MMIO responder for switches, debounced buttons (sticky W1C edges) and the display register.
// Optional MMIO_IRQ_EN adds a registered irq_o raised while any edge flag is pending.
module mmio_input_port
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int unsigned NUM_SW          = 16,
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic               we_i,
    input  logic               re_i,
    output logic               hit_o,
    output logic [31:0]        rdata_o,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [31:0]        disp_o
`ifdef MMIO_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    logic [NUM_SW-1:0]  r_sw_meta;
    logic [NUM_SW-1:0]  r_sw_sync;
    logic [NUM_BTN-1:0] r_btn_edge;
    logic [7:0]         r_evt_cnt;
    logic [31:0]        r_disp;
    logic [31:0]        r_rdata;

    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_clr_mask;
    logic [NUM_BTN-1:0] w_btn_edge_d;
    logic [7:0]         w_rise_cnt;
    logic [31:0]        w_rdata_d;
    reg_sel_e           w_sel;
    logic               w_hit;
    logic               w_w1c;
    logic               w_disp_we;

    assign w_hit     = (addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_sel     = decode_offset(addr_i[7:0]);
    assign w_w1c     = w_hit & we_i & (w_sel == RegBtnEdge);
    assign w_disp_we = w_hit & we_i & (w_sel == RegDisp);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk  (clk),
            .i_rst_n(rst),
            .i_btn  (btn_i[g]),
            .o_rise (w_rise[g])
        );
    end

    // A rise wins over a same-cycle clear of the same bit.
    assign w_clr_mask   = w_w1c ? wdata_i[NUM_BTN-1:0] : '0;
    assign w_btn_edge_d = w_rise | (r_btn_edge & ~w_clr_mask);

    always_comb begin
        w_rise_cnt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_rise_cnt = w_rise_cnt + 8'(w_rise[i]);
        end
    end

    always_comb begin
        w_rdata_d = '0;
        unique case (w_sel)
            RegSw:      w_rdata_d = 32'(r_sw_sync);
            RegBtnEdge: w_rdata_d = 32'(r_btn_edge);
            RegDisp:    w_rdata_d = r_disp;
            RegStatus: begin
                w_rdata_d[STATUS_PEND_BIT]               = |r_btn_edge;
                w_rdata_d[STATUS_CNT_MSB:STATUS_CNT_LSB] = r_evt_cnt;
            end
            default:    w_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_edge <= '0;
            r_evt_cnt  <= '0;
            r_disp     <= '0;
            r_rdata    <= '0;
        end else begin
            r_sw_meta  <= sw_i;
            r_sw_sync  <= r_sw_meta;
            r_btn_edge <= w_btn_edge_d;
            r_evt_cnt  <= r_evt_cnt + w_rise_cnt;
            if (w_disp_we) begin
                r_disp <= wdata_i;
            end
            if (w_hit && re_i) begin
                r_rdata <= w_rdata_d;
            end
        end
    end

`ifdef MMIO_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_btn_edge_d;
        end
    end

    assign irq_o = r_irq;
`endif

    assign hit_o   = w_hit;
    assign rdata_o = r_rdata;
    assign disp_o  = r_disp;

endmodule

// File: tb/tb_mmio_input_port.sv
// Scoreboard bench for mmio_input_port: reads push expected data, a negedge monitor pops it.
module tb_mmio_input_port;

    localparam int unsigned DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic        hit_o;
    logic [31:0] rdata_o;
    logic [15:0] sw_i = '0;
    logic [3:0]  btn_i = '0;
    logic [31:0] disp_o;
`ifdef MMIO_IRQ_EN
    logic        irq_o;
`endif

    mmio_input_port #(
        .BASE_ADDR      (32'h0000_0400),
        .NUM_SW         (16),
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .we_i   (we_i),
        .re_i   (re_i),
        .hit_o  (hit_o),
        .rdata_o(rdata_o),
        .sw_i   (sw_i),
        .btn_i  (btn_i),
        .disp_o (disp_o)
`ifdef MMIO_IRQ_EN
        ,
        .irq_o  (irq_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic r_pend   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Bench-side decode of a load accepted at this edge.
    always @(posedge clk) r_pend <= re_i && (addr_i[31:8] == 24'h00_0004);

    always @(negedge clk) begin
        if (r_pend) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq(e.tag, rdata_o, e.val);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input string tag, input logic [31:0] exp);
        exp_t e;
        if (re && a[31:8] == 24'h00_0004) begin
            e.tag = tag;
            e.val = exp;
            exp_q.push_back(e);
        end
        addr_i  = a;
        wdata_i = wd;
        we_i    = we;
        re_i    = re;
        @(posedge clk);
        #1;
        we_i = 1'b0;
        re_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus(a, 32'h0, 1'b0, 1'b1, tag, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        bus(a, wd, 1'b1, 1'b0, "wr", 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_eq("rst_disp", disp_o, 32'h0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        cycles(2);
        rst = 1'b1;

        rd(32'h408, "rd_disp_rst", 32'h0);
        @(negedge clk);
        check_eq("disp_after_rst", disp_o, 32'h0);

        wr(32'h408, 32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("disp_store", disp_o, 32'hDEAD_BEEF);
        rd(32'h408, "rd_disp", 32'hDEAD_BEEF);

        addr_i = 32'h500;
        #1;
        check_eq("hit_miss", 32'(hit_o), 32'h0);
        rd(32'h500, "rd_miss", 32'h0);
        @(negedge clk);
        check_eq("rdata_hold", rdata_o, 32'hDEAD_BEEF);

        sw_i = 16'hA5A5;
        cycles(3);
        rd(32'h400, "rd_sw", 32'h0000_A5A5);
        addr_i = 32'h410;
        #1;
        check_eq("hit_hole", 32'(hit_o), 32'h1);
        rd(32'h410, "rd_hole", 32'h0);
        wr(32'h410, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("disp_hole_wr", disp_o, 32'hDEAD_BEEF);

        bus(32'h408, 32'h1234_5678, 1'b1, 1'b1, "rd_pre_write", 32'hDEAD_BEEF);
        rd(32'h408, "rd_post_write", 32'h1234_5678);

        // Glitch of two samples must not be accepted.
        btn_i[2] = 1'b1;
        cycles(2);
        btn_i[2] = 1'b0;
        cycles(10);
        rd(32'h404, "edge_glitch", 32'h0);
        rd(32'h40C, "status_glitch", 32'h0);

        btn_i[2] = 1'b1;
        cycles(12);
        rd(32'h404, "edge_press", 32'h4);
        rd(32'h40C, "status_press", 32'h011);
`ifdef MMIO_IRQ_EN
        check_eq("irq_press", 32'(irq_o), 32'h1);
`endif

        btn_i[2] = 1'b0;
        cycles(10);
        rd(32'h404, "edge_release", 32'h4);

        // Clear lands on the same edge the second rise is captured.
        btn_i[2] = 1'b1;
        cycles(1 + DEB);
        wr(32'h404, 32'h4);
        rd(32'h404, "edge_set_wins", 32'h4);
        rd(32'h40C, "status_two", 32'h021);

        wr(32'h404, 32'h4);
`ifdef MMIO_IRQ_EN
        @(negedge clk);
        check_eq("irq_cleared", 32'(irq_o), 32'h0);
`endif
        rd(32'h404, "edge_cleared", 32'h0);
        rd(32'h40C, "status_cleared", 32'h020);

        btn_i[2] = 1'b0;
        cycles(10);
        btn_i[2] = 1'b1;
        cycles(4);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_disp", disp_o, 32'h0);
        check_eq("midrst_rdata", rdata_o, 32'h0);
`ifdef MMIO_IRQ_EN
        check_eq("midrst_irq", 32'(irq_o), 32'h0);
`endif
        cycles(2);
        rst = 1'b1;
        cycles(10);
        rd(32'h404, "edge_after_rst", 32'h4);
        rd(32'h40C, "status_after_rst", 32'h011);
        rd(32'h408, "disp_after_midrst", 32'h0);

        cycles(3);
        check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
